// File: rtl/vote_button_bank.sv
// vote_button_bank: multi-channel button front end for the voting machine.
// Each raw button is synchronized and debounced on its own; a small arbiter
// turns debounced presses into exactly one vote per physical press and
// reports simultaneous presses as an error strobe instead of a vote.
module vote_button_bank #(
    parameter int NUM_BUTTONS     = 4,
    parameter int DEBOUNCE_CYCLES = 10,
    parameter int SYNC_STAGES     = 2,
    parameter int ID_WIDTH        = $clog2(NUM_BUTTONS)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_BUTTONS-1:0] button,
    input  logic                   enable,
    output logic [NUM_BUTTONS-1:0] press_pulse,
    output logic [NUM_BUTTONS-1:0] held,
    output logic                   vote_valid,
    output logic [ID_WIDTH-1:0]    vote_id,
    output logic                   multi_press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    // Last count value before a new level is accepted; the counter saturates
    // here and never wraps.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        ARMED  = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    logic [NUM_BUTTONS-1:0] sync_q [SYNC_STAGES];
    logic [NUM_BUTTONS-1:0] s;
    logic [CNT_W-1:0]       count_q [NUM_BUTTONS];

    arb_state_t          state_q, state_d;
    logic                vote_valid_d;
    logic                multi_press_d;
    logic [ID_WIDTH-1:0] vote_id_d;
    logic [ID_WIDTH-1:0] pressed_id;
    logic                single_press;

    assign s = sync_q[SYNC_STAGES-1];

    // Shift raw button levels through the synchronizer chain.
    always_ff @(posedge clock or posedge reset) begin
        // NOTE: sequential state is written with <= so every flop samples the
        // pre-edge values; a blocking = here would collapse the chain.
        if (reset) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
        end else begin
            sync_q[0] <= button;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    // Per-channel debounce: accept a new level only after it persists, and
    // emit a one-cycle pulse on each accepted 0->1 transition.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            // NOTE: the counter array is plain flops, not RAM, so it is reset
            // element by element like any other state.
            for (int i = 0; i < NUM_BUTTONS; i++) begin
                count_q[i] <= '0;
            end
            held        <= '0;
            press_pulse <= '0;
        end else begin
            for (int i = 0; i < NUM_BUTTONS; i++) begin
                press_pulse[i] <= 1'b0;
                if (s[i] == held[i]) begin
                    count_q[i] <= '0;
                end else if (count_q[i] < CNT_LAST) begin
                    count_q[i] <= count_q[i] + CNT_W'(1);
                end else begin
                    held[i]        <= s[i];
                    count_q[i]     <= '0;
                    // s differs from held here, so s=1 means a rising level.
                    press_pulse[i] <= s[i];
                end
            end
        end
    end

    // Locate the pressed channel; only meaningful when exactly one bit is set.
    always_comb begin
        pressed_id   = '0;
        single_press = $onehot(press_pulse);
        for (int i = NUM_BUTTONS - 1; i >= 0; i--) begin
            if (press_pulse[i]) begin
                pressed_id = ID_WIDTH'(i);
            end
        end
    end

    // Arbiter next-state and strobe decode.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a value unassigned and no latch is inferred.
        state_d       = state_q;
        vote_valid_d  = 1'b0;
        multi_press_d = 1'b0;
        vote_id_d     = vote_id;
        case (state_q)
            ARMED: begin
                if (enable && (press_pulse != '0)) begin
                    if (single_press) begin
                        vote_valid_d = 1'b1;
                        vote_id_d    = pressed_id;
                    end else begin
                        multi_press_d = 1'b1;
                    end
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                // Re-arm only once every channel is debounced-released.
                if (held == '0) begin
                    state_d = ARMED;
                end
            end
            default: state_d = ARMED;
        endcase
    end

    // Arbiter state and registered vote outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ARMED;
            vote_valid  <= 1'b0;
            multi_press <= 1'b0;
            vote_id     <= '0;
        end else begin
            state_q     <= state_d;
            vote_valid  <= vote_valid_d;
            multi_press <= multi_press_d;
            vote_id     <= vote_id_d;
        end
    end

endmodule

// File: tb/tb_vote_button_bank.sv
// Testbench for vote_button_bank: directed scenarios followed by random
// button/enable activity, all checked every cycle against a window-based
// reference model of debounce and arbitration.
module tb_vote_button_bank;

    localparam int NB   = 4;
    localparam int DC   = 10;
    localparam int SYNC = 2;
    localparam int IDW  = $clog2(NB);

    logic            clock;
    logic            reset;
    logic [NB-1:0]   button;
    logic            enable;
    logic [NB-1:0]   press_pulse;
    logic [NB-1:0]   held;
    logic            vote_valid;
    logic [IDW-1:0]  vote_id;
    logic            multi_press;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    logic [NB-1:0]  raw_hist [$];   // raw samples still inside the synchronizer
    logic [NB-1:0]  s_hist   [$];   // last DC synchronized samples
    logic [NB-1:0]  m_held;
    logic [NB-1:0]  m_pulse;
    logic           m_valid;
    logic           m_multi;
    logic [IDW-1:0] m_id;
    bit             m_armed;

    vote_button_bank #(
        .NUM_BUTTONS     (NB),
        .DEBOUNCE_CYCLES (DC),
        .SYNC_STAGES     (SYNC)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .button      (button),
        .enable      (enable),
        .press_pulse (press_pulse),
        .held        (held),
        .vote_valid  (vote_valid),
        .vote_id     (vote_id),
        .multi_press (multi_press)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        raw_hist.delete();
        s_hist.delete();
        m_held  = '0;
        m_pulse = '0;
        m_valid = 1'b0;
        m_multi = 1'b0;
        m_id    = '0;
        m_armed = 1'b1;
    endtask

    // One clock edge of the reference model, using the inputs seen at the edge.
    // A channel's level flips once its last DC synchronized samples all show
    // the opposite level; a vote needs an armed arbiter, enable and exactly
    // one new press.
    task automatic model_edge();
        logic [NB-1:0] s_now;
        logic [NB-1:0] new_held;
        bit            all_opp;
        raw_hist.push_back(button);
        if (raw_hist.size() > SYNC) begin
            s_now = raw_hist.pop_front();
        end else begin
            s_now = '0;
        end
        s_hist.push_back(s_now);
        if (s_hist.size() > DC) void'(s_hist.pop_front());

        new_held = m_held;
        if (s_hist.size() == DC) begin
            for (int i = 0; i < NB; i++) begin
                all_opp = 1'b1;
                foreach (s_hist[j]) begin
                    if (s_hist[j][i] == m_held[i]) all_opp = 1'b0;
                end
                if (all_opp) new_held[i] = ~m_held[i];
            end
        end

        m_valid = 1'b0;
        m_multi = 1'b0;
        if (m_armed) begin
            if (enable && m_pulse != '0) begin
                if ($countones(m_pulse) == 1) begin
                    m_valid = 1'b1;
                    for (int i = 0; i < NB; i++) begin
                        if (m_pulse[i]) m_id = IDW'(i);
                    end
                end else begin
                    m_multi = 1'b1;
                end
                m_armed = 1'b0;
            end
        end else if (m_held == '0) begin
            m_armed = 1'b1;
        end

        m_pulse = new_held & ~m_held;
        m_held  = new_held;
    endtask

    task automatic compare_all();
        check("press_pulse", 32'(press_pulse), 32'(m_pulse));
        check("held",        32'(held),        32'(m_held));
        check("vote_valid",  32'(vote_valid),  32'(m_valid));
        check("vote_id",     32'(vote_id),     32'(m_id));
        check("multi_press", 32'(multi_press), 32'(m_multi));
    endtask

    // Drive inputs just after an edge, run one edge, then check 1 time unit later.
    task automatic cycle(input logic [NB-1:0] b, input logic en);
        button = b;
        enable = en;
        @(posedge clock);
        model_edge();
        #1;
        compare_all();
    endtask

    initial begin
        logic [NB-1:0] rb;
        logic          ren;
        int            dur;

        reset  = 1'b1;
        button = '0;
        enable = 1'b0;
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        check("reset_press_pulse", 32'(press_pulse), 32'h0);
        check("reset_held",        32'(held),        32'h0);
        check("reset_vote_valid",  32'(vote_valid),  32'h0);
        check("reset_vote_id",     32'(vote_id),     32'h0);
        check("reset_multi_press", 32'(multi_press), 32'h0);

        // 1: single press on button 2 gives exactly one vote.
        for (int k = 1; k <= 20; k++) begin
            cycle(4'b0100, 1'b1);
            if (k == 11) check("t1_no_pulse_edge11", 32'(press_pulse), 32'h0);
            if (k == 12) check("t1_pulse_edge12",    32'(press_pulse), 32'h4);
            if (k == 12) check("t1_held_edge12",     32'(held),        32'h4);
            if (k == 13) check("t1_vote_valid",      32'(vote_valid),  32'h1);
            if (k == 13) check("t1_vote_id",         32'(vote_id),     32'h2);
            if (k == 20) check("t1_no_repeat",       32'(vote_valid),  32'h0);
        end
        for (int k = 0; k < 14; k++) cycle(4'b0000, 1'b1);
        check("t1_released", 32'(held), 32'h0);

        // 2: glitches of 9 synchronized cycles never reach held.
        for (int k = 0; k < 9; k++) cycle(4'b0010, 1'b1);
        for (int k = 0; k < 3; k++) cycle(4'b0000, 1'b1);
        for (int k = 0; k < 9; k++) cycle(4'b0010, 1'b1);
        for (int k = 0; k < 14; k++) begin
            cycle(4'b0000, 1'b1);
            check("t2_held_zero", 32'(held), 32'h0);
        end

        // 3: press during lockout is ignored; a later clean press votes.
        for (int k = 0; k < 20; k++) cycle(4'b0001, 1'b1);
        check("t3_vote0_id", 32'(vote_id), 32'h0);
        for (int k = 1; k <= 20; k++) begin
            cycle(4'b1001, 1'b1);
            if (k == 12) check("t3_locked_pulse3", 32'(press_pulse), 32'h8);
            if (k == 13) check("t3_locked_novote", 32'(vote_valid),  32'h0);
        end
        for (int k = 0; k < 14; k++) cycle(4'b0000, 1'b1);
        for (int k = 1; k <= 20; k++) begin
            cycle(4'b1000, 1'b1);
            if (k == 13) check("t3_vote3_valid", 32'(vote_valid), 32'h1);
            if (k == 13) check("t3_vote3_id",    32'(vote_id),    32'h3);
        end
        for (int k = 0; k < 14; k++) cycle(4'b0000, 1'b1);

        // 4: simultaneous press raises multi_press, not a vote.
        for (int k = 1; k <= 20; k++) begin
            cycle(4'b1010, 1'b1);
            if (k == 12) check("t4_pulse_both", 32'(press_pulse), 32'ha);
            if (k == 13) check("t4_multi",      32'(multi_press), 32'h1);
            if (k == 13) check("t4_no_vote",    32'(vote_valid),  32'h0);
            if (k == 13) check("t4_id_kept",    32'(vote_id),     32'h3);
        end
        for (int k = 0; k < 14; k++) cycle(4'b0000, 1'b1);

        // 5: press while disabled never votes, even once enable rises.
        for (int k = 0; k < 20; k++) cycle(4'b0010, 1'b0);
        for (int k = 0; k < 10; k++) begin
            cycle(4'b0010, 1'b1);
            check("t5_no_vote", 32'(vote_valid), 32'h0);
        end
        for (int k = 0; k < 14; k++) cycle(4'b0000, 1'b1);
        for (int k = 1; k <= 20; k++) begin
            cycle(4'b0010, 1'b1);
            if (k == 13) check("t5_vote1_valid", 32'(vote_valid), 32'h1);
            if (k == 13) check("t5_vote1_id",    32'(vote_id),    32'h1);
        end
        for (int k = 0; k < 14; k++) cycle(4'b0000, 1'b1);

        // 6: asynchronous reset mid-count while LOCKED.
        for (int k = 0; k < 13; k++) cycle(4'b0100, 1'b1);
        check("t6_pre_vote_id", 32'(vote_id), 32'h2);
        for (int k = 0; k < 9; k++) cycle(4'b0101, 1'b1);
        #3;
        reset = 1'b1;
        #1;
        check("t6_rst_press_pulse", 32'(press_pulse), 32'h0);
        check("t6_rst_held",        32'(held),        32'h0);
        check("t6_rst_vote_valid",  32'(vote_valid),  32'h0);
        check("t6_rst_vote_id",     32'(vote_id),     32'h0);
        check("t6_rst_multi_press", 32'(multi_press), 32'h0);
        button = '0;
        @(posedge clock);
        #3;
        reset = 1'b0;
        model_reset();
        for (int k = 1; k <= 20; k++) begin
            cycle(4'b0001, 1'b1);
            if (k == 12) check("t6_pulse0",    32'(press_pulse), 32'h1);
            if (k == 13) check("t6_vote_valid", 32'(vote_valid), 32'h1);
            if (k == 13) check("t6_vote_id",   32'(vote_id),     32'h0);
        end
        for (int k = 0; k < 14; k++) cycle(4'b0000, 1'b1);

        // Random segments of button patterns, durations and enable levels.
        for (int seg = 0; seg < 40; seg++) begin
            rb  = NB'($urandom_range(0, (1 << NB) - 1));
            ren = ($urandom_range(0, 3) != 0);
            dur = $urandom_range(1, 25);
            for (int k = 0; k < dur; k++) cycle(rb, ren);
            if ($urandom_range(0, 2) == 0) begin
                for (int k = 0; k < 14; k++) cycle(4'b0000, 1'b1);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vote_button_bank.md
Name: vote_button_bank

Overview:
Multi-channel successor to the single-button debouncer for the voting machine. It debounces NUM_BUTTONS candidate buttons independently and produces per-channel one-cycle press pulses and debounced held levels. An arbitration/lockout FSM turns these into exactly one vote per physical press, and flags simultaneous presses as an error instead of a vote. It sits between the raw button pins and the vote tally logic.

Parameters:
NUM_BUTTONS, 4, number of independent button channels (>=2)
DEBOUNCE_CYCLES, 10, consecutive synchronized cycles a new level must persist before it is accepted (>=1)
SYNC_STAGES, 2, flip-flops in each input synchronizer (>=2)
ID_WIDTH, $clog2(NUM_BUTTONS), width of vote_id (derived; do not override)

Ports:
clock  input  1  system clock, all logic on posedge
reset  input  1  asynchronous, active-high reset
button  input  NUM_BUTTONS  raw, asynchronous button levels (1 = pressed)
enable  input  1  1 = votes may be accepted; 0 = presses are ignored by the arbiter
press_pulse  output  NUM_BUTTONS  one-cycle pulse per channel on accepted debounced press
held  output  NUM_BUTTONS  debounced level per channel
vote_valid  output  1  one-cycle strobe: a single-button vote was accepted
vote_id  output  ID_WIDTH  index of the voted button; holds until the next vote
multi_press  output  1  one-cycle strobe: more than one press_pulse in the same cycle while armed

Behaviour:
- Reset (async, active-high): all synchronizer flops, counters, held, press_pulse, vote_valid, vote_id and multi_press are 0. The FSM is in ARMED. Everything is reasserted immediately when reset asserts mid-operation, including mid-count and while LOCKED.
- Synchronizer: button[i] passes through SYNC_STAGES flops. Its output is s[i].
- Per-channel debounce:
  - Counter width is $clog2(DEBOUNCE_CYCLES+1) and never wraps.
  - If s[i]==held[i], the counter is cleared to 0.
  - Otherwise, if the counter is below DEBOUNCE_CYCLES-1, the counter increments.
  - Otherwise, held[i] <= s[i] and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES synchronized cycles clears the counter and never changes held.
- press_pulse[i]: registered high for exactly one cycle on the edge where held[i] goes 0->1. It stays 0 on 1->0.
  - Latency: press_pulse[i] is high in the cycle after the (SYNC_STAGES+DEBOUNCE_CYCLES)-th consecutive edge that samples button[i]=1. With defaults, this is the 12th edge.
  - Release likewise takes SYNC_STAGES+DEBOUNCE_CYCLES edges to clear held[i].
  - Holding the button indefinitely produces no further pulses.
- Arbiter FSM, states ARMED and LOCKED, evaluated on press_pulse:
  - ARMED, enable=1, exactly one press_pulse bit k set: next edge gives vote_valid=1 for one cycle and vote_id=k; go LOCKED.
  - ARMED, enable=1, two or more bits set: next edge gives multi_press=1 for one cycle; vote_valid stays 0 and vote_id is unchanged; go LOCKED.
  - ARMED, enable=0: pulses are ignored and the FSM stays ARMED. A button still held when enable rises does not vote.
  - LOCKED: all press_pulse are ignored, regardless of enable. Return to ARMED on the edge after held==0 (all channels released).
- Latency: vote_valid/multi_press are one cycle after press_pulse, i.e. SYNC_STAGES+DEBOUNCE_CYCLES+1 edges after the raw press.
- vote_valid and multi_press are never high in the same cycle.
- Neither can reassert until every button has been debounced-released.

Test Plan:
1. Reset, then hold button=4'b0100 for 20 cycles -> press_pulse=4'b0100 for exactly one cycle after the 12th edge; held[2]=1; vote_valid=1 one cycle later with vote_id=2; no further strobes while held.
2. Pulse button[1] high for 9 cycles, low for 3, high for 9 -> held, press_pulse and vote_valid remain 0 throughout.
3. After a vote on button 0, press button 3 while button 0 is still held -> press_pulse[3] fires but vote_valid stays 0 (LOCKED). Release both for 12+ cycles, press button 3 -> vote_valid=1, vote_id=3.
4. Assert button=4'b1010 on the same edge for 20 cycles -> press_pulse=4'b1010 in one cycle; multi_press=1 for one cycle; vote_valid=0; vote_id keeps its prior value.
5. enable=0, press button 1 for 20 cycles, then raise enable while still held -> no vote_valid. Release, set enable=1, press button 1 again -> vote_valid=1, vote_id=1.
6. Assert reset asynchronously (between edges) when the button-0 counter is at 7 and the FSM is LOCKED -> all outputs are 0 immediately. After release, the FSM is ARMED and a full 12-edge press on button 0 yields vote_id=0.
